cfeb_rdout_rcvr: RTL and testbench

//  Receiver for one CFEB readout stream: the stage directly downstream of the CFEB data port.

---
 rtl/cfeb_rdout_pkg.sv | 50 +++++
 rtl/cfeb_rdout_fifo.sv | 55 +++++
 rtl/cfeb_rdout_rcvr.sv | 182 ++++++++++++++++++
 tb/tb_cfeb_rdout_rcvr.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfeb_rdout_pkg.sv
// Shared types and helpers for the CFEB readout receiver.
// Entry format is {last, word}.
package cfeb_rdout_pkg;

  localparam int WORD_W  = 16;
  localparam int ENTRY_W = WORD_W + 1;
  localparam int CNT_W   = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] word;
  } entry_t;

  function automatic logic [WORD_W-1:0] csum_next(
    input logic [WORD_W-1:0] c,
    input logic [WORD_W-1:0] w
  );
    return c ^ w;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] maj_cnt(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic state_t maj_st(
    input state_t a,
    input state_t b,
    input state_t c
  );
    return state_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/cfeb_rdout_fifo.sv
// First-word-fall-through FIFO; the head entry is always on o_rd_data.
// Reads zero while empty so the output is clean out of reset.
module cfeb_rdout_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2048
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_rd;
  logic             w_wr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop at full frees the slot the push lands in.
  assign w_rd = i_rd_en & ~w_empty;
  assign w_wr = i_wr_en & (~w_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign o_rd_data = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_empty   = w_empty;
  assign o_full    = w_full;

endmodule

// File: rtl/cfeb_rdout_rcvr.sv
// CFEB readout stream receiver: input stage, framing FSM,
// length/checksum check and FWFT buffering for the event builder.
module cfeb_rdout_rcvr
  import cfeb_rdout_pkg::*;
#(
  parameter int EVT_WORDS  = 1600,
  parameter int FIFO_DEPTH = 2048,
  parameter int TMR        = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_b,
  input  logic [WORD_W-1:0]  i_din,
  input  logic               i_lpush_b,
  input  logic               i_endword,
  input  logic               i_rd_en,
  output logic [ENTRY_W-1:0] o_dout,
  output logic               o_empty,
  output logic               o_evt_done,
  output logic               o_crc_err,
  output logic               o_len_err,
  output logic               o_ovfl,
  output logic [CNT_W-1:0]   o_evt_cnt
);

  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  logic              r_s1_vld;
  logic [WORD_W-1:0] r_s1_word;
  logic              r_s1_end;

  state_t            r_state_q [NCOPY];
  logic [CNT_W-1:0]  r_wcnt_q  [NCOPY];
  state_t            w_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_wcnt;
  logic [CNT_W-1:0]  w_wcnt_nxt;

  logic [WORD_W-1:0] r_csum;
  logic [WORD_W-1:0] r_chk;
  logic              r_force_len;
  logic              r_ovfl;
  logic [CNT_W-1:0]  r_evt_cnt;

  logic              w_start;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_fire;
  logic              w_wr_req;
  logic              w_drop;
  logic              w_wr_en;
  entry_t            w_wr_data;
  logic [CNT_W-1:0]  w_base_cnt;
  logic [WORD_W-1:0] w_base_cs;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
      r_s1_end  <= 1'b0;
    end else begin
      r_s1_vld  <= ~i_lpush_b;
      r_s1_word <= i_din;
      r_s1_end  <= i_endword;
    end
  end

  generate
    if (NCOPY == 3) begin : g_vote
      assign w_state = maj_st(r_state_q[0], r_state_q[1],
                              r_state_q[2]);
      assign w_wcnt  = maj_cnt(r_wcnt_q[0], r_wcnt_q[1],
                               r_wcnt_q[2]);
    end else begin : g_single
      assign w_state = r_state_q[0];
      assign w_wcnt  = r_wcnt_q[0];
    end
  endgenerate

  // Every copy reloads from the voted value, scrubbing upsets.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      for (int k = 0; k < NCOPY; k++) begin
        r_state_q[k] <= ST_IDLE;
        r_wcnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NCOPY; k++) begin
        r_state_q[k] <= w_state_nxt;
        r_wcnt_q[k]  <= w_wcnt_nxt;
      end
    end
  end

  // CHECK also accepts the first word of a back-to-back event.
  assign w_start   = (w_state == ST_IDLE) ||
                     (w_state == ST_CHECK);
  assign w_rd_fire = i_rd_en & ~w_empty;
  assign w_wr_req  = r_s1_vld & (w_state != ST_FLUSH);
  assign w_drop    = w_wr_req & w_full & ~w_rd_fire;
  assign w_wr_en   = w_wr_req & ~w_drop;
  assign w_wr_data = '{last: r_s1_end, word: r_s1_word};

  assign w_base_cnt = w_start ? '0 : w_wcnt;
  assign w_base_cs  = w_start ? '0 : r_csum;

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      ST_IDLE, ST_RECV, ST_CHECK: begin
        if (r_s1_vld) begin
          if (r_s1_end)    w_state_nxt = ST_CHECK;
          else if (w_drop) w_state_nxt = ST_FLUSH;
          else             w_state_nxt = ST_RECV;
        end else if (w_state == ST_CHECK) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (r_s1_vld && r_s1_end) w_state_nxt = ST_CHECK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wcnt_nxt = w_wcnt;
    if (w_wr_req) begin
      w_wcnt_nxt = r_s1_end ? w_base_cnt
                            : cnt_inc(w_base_cnt);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_csum      <= '0;
      r_chk       <= '0;
      r_force_len <= 1'b0;
      r_ovfl      <= 1'b0;
      r_evt_cnt   <= '0;
    end else begin
      if (w_wr_req) begin
        r_csum <= r_s1_end ? w_base_cs
                           : csum_next(w_base_cs, r_s1_word);
        r_force_len <= (w_start ? 1'b0 : r_force_len) | w_drop;
      end
      if (r_s1_vld && r_s1_end) r_chk <= r_s1_word;
      if (w_drop) r_ovfl <= 1'b1;
      if (w_state == ST_CHECK) r_evt_cnt <= r_evt_cnt + 1'b1;
    end
  end

  always_comb begin
    o_evt_done = 1'b0;
    o_crc_err  = 1'b0;
    o_len_err  = 1'b0;
    if (w_state == ST_CHECK) begin
      o_evt_done = 1'b1;
      o_crc_err  = (r_chk != r_csum);
      o_len_err  = r_force_len ||
                   (w_wcnt != CNT_W'(EVT_WORDS));
    end
  end

  cfeb_rdout_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_b   (i_rst_b),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_dout),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign o_empty   = w_empty;
  assign o_ovfl    = r_ovfl;
  assign o_evt_cnt = r_evt_cnt;

endmodule

// File: tb/tb_cfeb_rdout_rcvr.sv
// Directed bench for cfeb_rdout_rcvr: vector table of events
// plus hand sequences for latency, overflow and mid-event reset.
module tb_cfeb_rdout_rcvr;

  logic        clk = 1'b0;
  logic        i_rst_b = 1'b0;
  logic [15:0] i_din = '0;
  logic        i_lpush_b = 1'b1;
  logic        i_endword = 1'b0;
  logic        i_rd_en = 1'b0;
  logic [16:0] o_dout;
  logic        o_empty;
  logic        o_evt_done;
  logic        o_crc_err;
  logic        o_len_err;
  logic        o_ovfl;
  logic [11:0] o_evt_cnt;

  always #5 clk = ~clk;

  cfeb_rdout_rcvr #(
    .EVT_WORDS  (1600),
    .FIFO_DEPTH (2048),
    .TMR        (1)
  ) dut (
    .i_clk      (clk),
    .i_rst_b    (i_rst_b),
    .i_din      (i_din),
    .i_lpush_b  (i_lpush_b),
    .i_endword  (i_endword),
    .i_rd_en    (i_rd_en),
    .o_dout     (o_dout),
    .o_empty    (o_empty),
    .o_evt_done (o_evt_done),
    .o_crc_err  (o_crc_err),
    .o_len_err  (o_len_err),
    .o_ovfl     (o_ovfl),
    .o_evt_cnt  (o_evt_cnt)
  );

  int errors = 0;
  int checks = 0;
  int rd_mode = 0;
  int ev_n = 0;
  logic ev_crc = 1'b0;
  logic ev_len = 1'b0;
  logic [16:0] pop_q[$];
  logic [16:0] exp_q[$];
  int exp_cnt = 0;

  typedef struct {
    int          nw;
    logic [15:0] cx;
    bit          gap;
    int          rdm;
    bit          ecrc;
    bit          elen;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Consumer and status monitor, both sampled on the falling edge.
  always @(negedge clk) begin
    if (o_evt_done) begin
      ev_n++;
      ev_crc = o_crc_err;
      ev_len = o_len_err;
    end
    case (rd_mode)
      0:       i_rd_en = 1'b0;
      1:       i_rd_en = 1'b1;
      default: i_rd_en = 1'($urandom_range(0, 1));
    endcase
    if (i_rd_en && !o_empty) pop_q.push_back(o_dout);
  end

  task automatic send_event(input int n,
                            input logic [15:0] cx,
                            input bit gap);
    logic [15:0] cs;
    cs = '0;
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      if (i <= n) begin
        i_din = 16'(i);
        i_endword = 1'b0;
        cs = cs ^ 16'(i);
        exp_q.push_back({1'b0, 16'(i)});
      end else begin
        i_din = cs ^ cx;
        i_endword = 1'b1;
        exp_q.push_back({1'b1, cs ^ cx});
      end
      i_lpush_b = 1'b0;
      if (gap) begin
        @(negedge clk);
        i_lpush_b = 1'b1;
        i_endword = 1'b0;
      end
    end
    @(negedge clk);
    i_lpush_b = 1'b1;
    i_endword = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    repeat (4) @(negedge clk);
    while (!o_empty && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({name, " drain_timeout"}, 32'(t >= 20000), 0);
  endtask

  task automatic cmp_data(input string name);
    int bad;
    int n;
    bad = -1;
    n = (pop_q.size() < exp_q.size()) ? pop_q.size()
                                      : exp_q.size();
    chk({name, " entry_count"}, pop_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (pop_q[i] !== exp_q[i] && bad < 0) bad = i;
    end
    chk({name, " first_bad_entry_idx"}, bad, -1);
    pop_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{1600, 16'h0000, 1'b0, 1, 1'b0, 1'b0};
    vecs[1] = '{1600, 16'h0001, 1'b0, 1, 1'b1, 1'b0};
    vecs[2] = '{1599, 16'h0000, 1'b0, 1, 1'b0, 1'b1};
    vecs[3] = '{1600, 16'h0000, 1'b1, 2, 1'b0, 1'b0};
    vecs[4] = '{1601, 16'h00ff, 1'b1, 2, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk("rst dout", o_dout, 0);
    chk("rst empty", o_empty, 1);
    chk("rst evt_done", o_evt_done, 0);
    chk("rst crc_err", o_crc_err, 0);
    chk("rst len_err", o_len_err, 0);
    chk("rst ovfl", o_ovfl, 0);
    chk("rst evt_cnt", o_evt_cnt, 0);
    @(negedge clk);
    i_rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-word event: latency and CHECK pulse timing.
    i_din = 16'h0000;
    i_endword = 1'b1;
    i_lpush_b = 1'b0;
    @(negedge clk);
    i_lpush_b = 1'b1;
    i_endword = 1'b0;
    chk("lat empty_s1", o_empty, 1);
    @(negedge clk);
    chk("lat empty_wr", o_empty, 0);
    chk("lat dout", o_dout, 17'h10000);
    chk("zw evt_done", o_evt_done, 1);
    chk("zw len_err", o_len_err, 1);
    chk("zw crc_err", o_crc_err, 0);
    @(negedge clk);
    chk("zw done_pulse", o_evt_done, 0);
    chk("zw evt_cnt", o_evt_cnt, 1);
    exp_cnt = 1;
    rd_mode = 1;
    repeat (3) @(negedge clk);
    chk("zw drained", o_empty, 1);
    pop_q.delete();
    exp_q.delete();

    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      rd_mode = vecs[v].rdm;
      ev_n = 0;
      send_event(vecs[v].nw, vecs[v].cx, vecs[v].gap);
      drain(nm);
      exp_cnt++;
      chk({nm, " evt_pulses"}, ev_n, 1);
      chk({nm, " crc_err"}, ev_crc, vecs[v].ecrc);
      chk({nm, " len_err"}, ev_len, vecs[v].elen);
      chk({nm, " evt_cnt"}, o_evt_cnt, exp_cnt);
      chk({nm, " ovfl"}, o_ovfl, 0);
      cmp_data(nm);
    end

    // Stalled consumer: second event overflows at word 2049.
    rd_mode = 0;
    ev_n = 0;
    send_event(1600, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf ev1 ovfl", o_ovfl, 0);
    chk("ovf ev1 len_err", ev_len, 0);
    send_event(1600, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    exp_cnt += 2;
    chk("ovf ovfl", o_ovfl, 1);
    chk("ovf evt_pulses", ev_n, 2);
    chk("ovf ev2 len_err", ev_len, 1);
    chk("ovf evt_cnt", o_evt_cnt, exp_cnt);
    while (exp_q.size() > 2048) void'(exp_q.pop_back());
    rd_mode = 1;
    drain("ovf");
    cmp_data("ovf");

    // Reset for one clock in the middle of an event.
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      i_din = 16'(i);
      i_lpush_b = 1'b0;
    end
    @(negedge clk);
    i_lpush_b = 1'b1;
    i_rst_b = 1'b0;
    #1;
    chk("mrst empty", o_empty, 1);
    chk("mrst dout", o_dout, 0);
    chk("mrst evt_cnt", o_evt_cnt, 0);
    chk("mrst ovfl", o_ovfl, 0);
    @(negedge clk);
    i_rst_b = 1'b1;
    @(negedge clk);
    pop_q.delete();
    exp_q.delete();
    ev_n = 0;
    send_event(1600, 16'h0000, 1'b0);
    drain("mrst");
    chk("mrst evt_pulses", ev_n, 1);
    chk("mrst crc_err", ev_crc, 0);
    chk("mrst len_err", ev_len, 0);
    chk("mrst evt_cnt_after", o_evt_cnt, 1);
    cmp_data("mrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
